seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's multiplexed 2-digit 7-segment display driver.
- Samples the time-multiplexed anode and segment lines and reconstructs the decimal digit shown on each position.
- Provides per-digit valid/error status and a frame-complete pulse.
- Used as an on-chip loopback monitor and a self-check source for display logic.

---
 rtl/seg7_pkg.sv | 61 ++++++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and scan-decoder types.
// Pattern bits are active-high with segment A at bit 6.
package seg7_pkg;

  localparam int SEG_A_BIT = 6;

  localparam logic [6:0] SEG_0 = 7'h7E;
  localparam logic [6:0] SEG_1 = 7'h30;
  localparam logic [6:0] SEG_2 = 7'h6D;
  localparam logic [6:0] SEG_3 = 7'h79;
  localparam logic [6:0] SEG_4 = 7'h33;
  localparam logic [6:0] SEG_5 = 7'h5B;
  localparam logic [6:0] SEG_6 = 7'h5F;
  localparam logic [6:0] SEG_7 = 7'h70;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h7B;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } scan_state_e;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] pat;
  } scan_smp_t;

  function automatic logic [2:0] low_count(
    input logic [3:0] an
  );
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~an[i]};
    end
    return n;
  endfunction

  function automatic logic [6:0] pack_pattern(
    input logic a,
    input logic b,
    input logic c,
    input logic d,
    input logic e,
    input logic f,
    input logic g
  );
    logic [6:0] p;
    p = '0;
    p[SEG_A_BIT]     = a;
    p[SEG_A_BIT - 1] = b;
    p[SEG_A_BIT - 2] = c;
    p[SEG_A_BIT - 3] = d;
    p[SEG_A_BIT - 4] = e;
    p[SEG_A_BIT - 5] = f;
    p[SEG_A_BIT - 6] = g;
    return p;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-high 7-segment pattern to its decimal value.
// Anything outside the ten numerals is flagged illegal.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] val,
  output logic       illegal
);

  always_comb begin
    val     = 4'd0;
    illegal = 1'b0;
    unique case (1'b1)
      (pat == SEG_0): val = 4'd0;
      (pat == SEG_1): val = 4'd1;
      (pat == SEG_2): val = 4'd2;
      (pat == SEG_3): val = 4'd3;
      (pat == SEG_4): val = 4'd4;
      (pat == SEG_5): val = 4'd5;
      (pat == SEG_6): val = 4'd6;
      (pat == SEG_7): val = 4'd7;
      (pat == SEG_8): val = 4'd8;
      (pat == SEG_9): val = 4'd9;
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs digits from multiplexed 7-segment anode/segment lines.
// Per-digit valid/error status, mux-conflict and frame-complete pulses.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic                    clck,
  input  logic                    rst_n,
  input  logic [3:0]              anode,
  input  logic                    seg_a,
  input  logic                    seg_b,
  input  logic                    seg_c,
  input  logic                    seg_d,
  input  logic                    seg_e,
  input  logic                    seg_f,
  input  logic                    seg_g,
  output logic [4*NUM_DIGITS-1:0] digit,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   seg_err,
  output logic                    mux_err,
  output logic                    frame_update
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [3:0]    AN_USE  = 4'((1 << NUM_DIGITS) - 1);

  scan_smp_t   in_d, in_q;
  logic [CW-1:0] cnt_d, cnt_q;
  scan_state_e st_d, st_q;

  logic [4*NUM_DIGITS-1:0] digit_d, digit_q;
  logic [NUM_DIGITS-1:0]   valid_d, valid_q;
  logic [NUM_DIGITS-1:0]   err_d, err_q;
  logic [NUM_DIGITS-1:0]   pend_d, pend_q;
  logic [NUM_DIGITS-1:0]   set_bits;
  logic [NUM_DIGITS-1:0][TW-1:0] to_d, to_q;

  logic       mux_d, mux_q;
  logic       fu_d, fu_q;
  logic       single, commit;
  logic [1:0] sel;
  logic [3:0] dec_val;
  logic       dec_bad;

  seg7_pattern_decode u_dec (
    .pat     (in_q.pat),
    .val     (dec_val),
    .illegal (dec_bad)
  );

  // Unused anode bits are forced high so they never look selected.
  always_comb begin
    in_d.an  = anode | ~AN_USE;
    in_d.pat = pack_pattern(~seg_a, ~seg_b, ~seg_c,
                            ~seg_d, ~seg_e, ~seg_f,
                            ~seg_g);
    mux_d    = low_count(in_d.an) >= 3'd2;
    if (in_d != in_q) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    single = low_count(in_q.an) == 3'd1;
    sel    = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!in_q.an[i]) sel = 2'(i);
    end
  end

  always_comb begin
    st_d   = st_q;
    commit = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (single) st_d = TRACK;
      end
      TRACK: begin
        if (!single) begin
          st_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          commit = 1'b1;
          st_d   = HELD;
        end
      end
      HELD: begin
        if (!single) begin
          st_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          st_d = TRACK;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  // Illegal commits flag the error but keep the old value and age.
  always_comb begin
    digit_d  = digit_q;
    valid_d  = valid_q;
    err_d    = err_q;
    set_bits = '0;
    to_d     = to_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (commit && (sel == 2'(i))) begin
        if (dec_bad) begin
          err_d[i] = 1'b1;
        end else begin
          digit_d[4*i +: 4] = dec_val;
          err_d[i]          = 1'b0;
          set_bits[i]       = 1'b1;
        end
      end
      if (set_bits[i]) begin
        to_d[i]    = '0;
        valid_d[i] = 1'b1;
      end else begin
        if (to_q[i] != TO_MAX) to_d[i] = to_q[i] + TO_ONE;
        if (to_d[i] == TO_MAX) valid_d[i] = 1'b0;
      end
    end
  end

  // A full mask pulses next cycle; a commit landing then starts the new mask.
  always_comb begin
    fu_d   = &pend_q;
    pend_d = (fu_d ? '0 : pend_q) | set_bits;
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= '{an: 4'hF, pat: 7'h00};
      cnt_q   <= '0;
      st_q    <= IDLE;
      digit_q <= '0;
      valid_q <= '0;
      err_q   <= '0;
      pend_q  <= '0;
      to_q    <= '0;
      mux_q   <= 1'b0;
      fu_q    <= 1'b0;
    end else begin
      in_q    <= in_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      digit_q <= digit_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
      mux_q   <= mux_d;
      fu_q    <= fu_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = valid_q;
  assign seg_err      = err_q;
  assign mux_err      = mux_q;
  assign frame_update = fu_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: vector table plus
// hand sequences for latency, framing, glitch, illegal and timeout.
module tb_seg7_scan_decoder;

  localparam int TO = 4096;

  logic       clck = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] anode;
  logic       seg_a, seg_b, seg_c, seg_d;
  logic       seg_e, seg_f, seg_g;
  logic [7:0] digit;
  logic [1:0] digit_valid;
  logic [1:0] seg_err;
  logic       mux_err;
  logic       frame_update;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clck = ~clck;
  always @(posedge clck) cyc <= cyc + 1;

  seg7_scan_decoder #(
    .NUM_DIGITS    (2),
    .STABLE_CYCLES (4),
    .TIMEOUT       (TO)
  ) dut (
    .clck         (clck),
    .rst_n        (rst_n),
    .anode        (anode),
    .seg_a        (seg_a),
    .seg_b        (seg_b),
    .seg_c        (seg_c),
    .seg_d        (seg_d),
    .seg_e        (seg_e),
    .seg_f        (seg_f),
    .seg_g        (seg_g),
    .digit        (digit),
    .digit_valid  (digit_valid),
    .seg_err      (seg_err),
    .mux_err      (mux_err),
    .frame_update (frame_update)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] pat;
    logic [7:0] dig;
    logic [1:0] err;
  } vec_t;

  vec_t vecs[14];

  task automatic drive(input logic [3:0] an, input logic [6:0] pat);
    anode = an;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = ~pat;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clck);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    int         n_fu;
    int         n_mux;
    int         e_commit;
    logic       seen3;
    logic [7:0] prev;

    vecs[0]  = '{4'b1110, 7'h7E, 8'h20, 2'b00};
    vecs[1]  = '{4'b1101, 7'h5F, 8'h60, 2'b00};
    vecs[2]  = '{4'b1110, 7'h70, 8'h67, 2'b00};
    vecs[3]  = '{4'b1101, 7'h7F, 8'h87, 2'b00};
    vecs[4]  = '{4'b1110, 7'h7B, 8'h89, 2'b00};
    vecs[5]  = '{4'b1101, 7'h33, 8'h49, 2'b00};
    vecs[6]  = '{4'b1110, 7'h79, 8'h43, 2'b00};
    vecs[7]  = '{4'b1110, 7'h01, 8'h43, 2'b01};
    vecs[8]  = '{4'b1101, 7'h5B, 8'h53, 2'b01};
    vecs[9]  = '{4'b1110, 7'h6D, 8'h52, 2'b00};
    vecs[10] = '{4'b1101, 7'h7C, 8'h52, 2'b10};
    vecs[11] = '{4'b1110, 7'h30, 8'h51, 2'b10};
    vecs[12] = '{4'b1101, 7'h7E, 8'h01, 2'b00};
    vecs[13] = '{4'b1110, 7'h7F, 8'h08, 2'b00};

    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'($urandom), 7'($urandom));
      step(1);
    end
    chk("rst_digit", digit, 0);
    chk("rst_valid", digit_valid, 0);
    chk("rst_err", seg_err, 0);
    chk("rst_mux", mux_err, 0);
    chk("rst_fu", frame_update, 0);
    drive(4'b1111, 7'h00);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_digit", digit, 0);
    chk("post_rst_valid", digit_valid, 0);

    // commit latency
    drive(4'b1110, 7'h5B);
    step(4);
    chk("lat_early_digit", digit, 0);
    chk("lat_early_valid", digit_valid, 0);
    step(1);
    chk("lat_digit", digit, 8'h05);
    chk("lat_valid", digit_valid, 2'b01);
    chk("lat_fu", frame_update, 0);
    step(1);
    chk("lat_fu_next", frame_update, 0);

    // multiplexed frames, anode[3:2] low but ignored
    n_fu  = 0;
    n_mux = 0;
    for (int f = 0; f < 8; f++) begin
      if (f % 2 == 0) drive(4'b0010, 7'h30);
      else            drive(4'b0001, 7'h6D);
      for (int k = 0; k < 8; k++) begin
        step(1);
        if (frame_update) n_fu++;
        if (mux_err) n_mux++;
      end
    end
    chk("frame_digit", digit, 8'h21);
    chk("frame_valid", digit_valid, 2'b11);
    chk("frame_pulses", n_fu, 4);
    chk("frame_no_mux", n_mux, 0);

    // vector table
    prev = 8'h21;
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].an, vecs[i].pat);
      step(4);
      chk($sformatf("vec%0d_hold", i), digit, prev);
      step(1);
      chk($sformatf("vec%0d_digit", i), digit, vecs[i].dig);
      chk($sformatf("vec%0d_err", i), seg_err, vecs[i].err);
      chk($sformatf("vec%0d_valid", i), digit_valid, 2'b11);
      step(1);
      prev = vecs[i].dig;
    end

    // glitch rejection on digit 0
    seen3 = 1'b0;
    drive(4'b1110, 7'h79);
    for (int k = 0; k < 3; k++) begin
      step(1);
      if (digit[3:0] == 4'd3) seen3 = 1'b1;
    end
    drive(4'b1110, 7'h30);
    for (int k = 0; k < 8; k++) begin
      step(1);
      if (digit[3:0] == 4'd3) seen3 = 1'b1;
    end
    chk("glitch_never3", seen3, 0);
    chk("glitch_digit", digit, 8'h01);

    // illegal blank pattern on digit 1
    drive(4'b1101, 7'h6D);
    step(8);
    chk("ill_pre_digit", digit, 8'h21);
    drive(4'b1101, 7'h00);
    step(8);
    chk("ill_err", seg_err, 2'b10);
    chk("ill_digit", digit, 8'h21);
    chk("ill_valid", digit_valid, 2'b11);
    drive(4'b1101, 7'h33);
    step(5);
    e_commit = cyc;
    chk("ill_fix_digit", digit, 8'h41);
    chk("ill_fix_err", seg_err, 2'b00);
    step(3);

    // multiple anodes low
    n_mux = 0;
    drive(4'b1100, 7'h33);
    for (int k = 0; k < 5; k++) begin
      step(1);
      if (mux_err) n_mux++;
    end
    drive(4'b1111, 7'h33);
    step(1);
    if (mux_err) n_mux++;
    chk("mux_pulses", n_mux, 5);
    chk("mux_digit", digit, 8'h41);

    // timeout boundary on digit 1
    while (cyc < e_commit + TO - 1) step(1);
    chk("to_edge_valid", digit_valid, 2'b10);
    step(1);
    chk("to_valid", digit_valid, 2'b00);
    chk("to_digit", digit, 8'h41);
    chk("to_err", seg_err, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
